i2s_dac_tx: RTL and testbench



---
 rtl/i2s_dac_tx.sv | 148 ++++++++++++++
 tb/tb_i2s_dac_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: I2S master transmitter for the WM8731 DAC.
// It runs in the codec master-clock domain and sends one stereo pair per
// 64-BCLK frame. Each channel slot is 32 BCLKs wide and carries the sample
// MSB first, starting one BCLK after the LRC change.
// Ports:
//   clk, rst_n          master clock; synchronous active-low reset
//   sample_l/sample_r   two's-complement PCM pair (WIDTH bits)
//   valid/ready         pair handshake; a pair is accepted on valid && ready
//   bclk/daclrc/dacdat  I2S bit clock, word select (1 = right), serial data
//   underrun            one-cycle pulse when a frame starts with no new pair
module i2s_dac_tx #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DIV   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample_l,
  input  logic [WIDTH-1:0] sample_r,
  input  logic             valid,
  output logic             ready,
  output logic             bclk,
  output logic             daclrc,
  output logic             dacdat,
  output logic             underrun
);

  localparam int unsigned DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             daclrc_q, daclrc_d;
  logic             dacdat_q, dacdat_d;
  logic             underrun_q, underrun_d;
  logic             ready_q, ready_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [WIDTH-1:0] cur_l_q, cur_l_d, cur_r_q, cur_r_d;

  logic             wrap;
  logic             frame_start;
  logic             accept;
  logic [4:0]       slot;
  logic [WIDTH-1:0] chan;
  logic [IDX_W-1:0] idx;

  // Next-state logic for timing, handshake and serializer.
  always_comb begin
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    daclrc_d   = daclrc_q;
    dacdat_d   = dacdat_q;
    underrun_d = 1'b0;
    full_d     = full_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    cur_l_d    = cur_l_q;
    cur_r_d    = cur_r_q;
    slot       = 5'd0;
    chan       = '0;
    idx        = '0;

    wrap        = (div_cnt_q == DIV_LAST);
    frame_start = wrap && (bit_cnt_q == 6'd63);
    // ready_q mirrors ~full_q outside reset, so this is the accept condition.
    accept      = valid && ready_q;

    div_cnt_d = wrap ? '0 : div_cnt_q + DIV_W'(1);
    if (wrap) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
    end
    bclk_d = (div_cnt_d >= DIV_HALF);

    // Frame boundary: promote the held pair, or repeat the last one.
    if (frame_start) begin
      if (full_q) begin
        cur_l_d = hold_l_q;
        cur_r_d = hold_r_q;
        full_d  = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end

    // ready is low while full, so this never collides with the load above.
    if (accept) begin
      hold_l_d = sample_l;
      hold_r_d = sample_r;
      full_d   = 1'b1;
    end

    ready_d = ~full_d;

    // Serial outputs change on BCLK falling edges; slot 0 is the I2S delay bit.
    if (wrap) begin
      daclrc_d = bit_cnt_d[5];
      slot     = bit_cnt_d[4:0];
      chan     = bit_cnt_d[5] ? cur_r_q : cur_l_q;
      idx      = IDX_W'(WIDTH - 32'(slot));
      if ((slot != 5'd0) && (32'(slot) <= WIDTH)) begin
        dacdat_d = chan[idx];
      end else begin
        dacdat_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= 6'd0;
      bclk_q     <= 1'b0;
      daclrc_q   <= 1'b0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;
      full_q     <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      cur_l_q    <= '0;
      cur_r_q    <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bclk_q     <= bclk_d;
      daclrc_q   <= daclrc_d;
      dacdat_q   <= dacdat_d;
      underrun_q <= underrun_d;
      ready_q    <= ready_d;
      full_q     <= full_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      cur_l_q    <= cur_l_d;
      cur_r_q    <= cur_r_d;
    end
  end

  assign ready    = ready_q;
  assign bclk     = bclk_q;
  assign daclrc   = daclrc_q;
  assign dacdat   = dacdat_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Testbench for i2s_dac_tx: a frame-level reference model pushes the expected
// stereo pair of every frame into a scoreboard queue. A monitor then samples
// dacdat/daclrc at each BCLK rise and checks every complete 64-bit frame.
module tb_i2s_dac_tx;

  localparam int W     = 24;
  localparam int D     = 6;
  localparam int FRAME = 64 * D;

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } pair_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sample_l, sample_r;
  logic         valid;
  logic         ready, bclk, daclrc, dacdat, underrun;

  int checks = 0;
  int errors = 0;
  int frames = 0;

  pair_t sb_q[$];

  // Reference model state
  int           n;
  logic         m_full, m_ready, m_acc;
  pair_t        m_hold, m_cur;

  i2s_dac_tx #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .sample_l(sample_l), .sample_r(sample_r),
    .valid(valid), .ready(ready), .bclk(bclk), .daclrc(daclrc),
    .dacdat(dacdat), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected 64-slot frame from the I2S slot rules; bit b is slot b.
  function automatic logic [63:0] frame_bits(input pair_t p);
    logic [63:0]  v;
    logic [W-1:0] ch;
    int           pos;
    v = '0;
    for (int b = 0; b < 64; b++) begin
      ch  = (b < 32) ? p.l : p.r;
      pos = b % 32;
      v[b] = (pos >= 1 && pos <= W) ? ch[W-pos] : 1'b0;
    end
    return v;
  endfunction

  // Reference model, evaluated once per clk edge with the inputs seen at that edge.
  always @(negedge clk) begin
    logic acc, exp_ur;
    if (!rst_n) begin
      n       = 0;
      m_full  = 1'b0;
      m_ready = 1'b0;
      m_acc   = 1'b0;
      m_hold  = '0;
      m_cur   = '0;
      sb_q.delete();
      sb_q.push_back(pair_t'(0));
      check("reset_outputs", 64'({ready, bclk, daclrc, dacdat, underrun}), 64'd0);
    end else begin
      n++;
      acc    = valid && m_ready;
      exp_ur = 1'b0;
      if (n % FRAME == 0) begin
        if (m_full) begin
          m_cur  = m_hold;
          m_full = 1'b0;
        end else begin
          exp_ur = 1'b1;
        end
      end
      if (acc) begin
        m_hold = {sample_l, sample_r};
        m_full = 1'b1;
      end
      if (n % FRAME == 0) sb_q.push_back(m_cur);
      m_acc   = acc;
      m_ready = !m_full;
      check("underrun", 64'(underrun), 64'(exp_ur));
      check("ready", 64'(ready), 64'(m_ready));
    end
  end

  // Monitor: codec-side capture on BCLK rises, frame comparison against the scoreboard.
  logic [63:0] cap_dat, cap_lrc;
  int          nb;
  int          since;
  logic        prev_b;
  always @(negedge clk) begin
    pair_t p;
    if (!rst_n) begin
      nb     = 0;
      since  = -1;
      prev_b = 1'b0;
    end else begin
      if (since >= 0) since++;
      if (bclk && !prev_b) begin
        if (since >= 0) check("bclk_period", 64'(since), 64'(D));
        since = 0;
        cap_dat[nb] = dacdat;
        cap_lrc[nb] = daclrc;
        nb++;
        if (nb == 64) begin
          nb = 0;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty actual=frame required=no_frame at t=%0t", $time);
          end else begin
            p = sb_q.pop_front();
            check("frame_dacdat", cap_dat, frame_bits(p));
            check("frame_daclrc", cap_lrc, {32'hFFFF_FFFF, 32'h0});
            frames++;
          end
        end
      end
      prev_b = bclk;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    valid = 1'b0;
    repeat (k) tick();
  endtask

  // Present a pair and hold it until the model sees it accepted (valid stays high).
  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
    logic got;
    got      = 1'b0;
    valid    = 1'b1;
    sample_l = l;
    sample_r = r;
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick();
      if (m_acc) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted at t=%0t", $time);
    end
  endtask

  task automatic wait_phase(input int ph);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (n % FRAME == ph) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    if (!hit) begin
      errors++;
      $display("FAIL wait_phase actual=missed required=%0d at t=%0t", ph, $time);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    valid    = 1'b0;
    sample_l = '0;
    sample_r = '0;
    repeat (4) tick();
    rst_n = 1'b1;

    // Idle: zero data, underrun at every frame start.
    idle(2 * FRAME + 20);

    // Known pattern.
    send(24'hABCDEF, 24'h123456);
    idle(FRAME);

    // Back-pressure: three pairs offered back to back.
    send(24'h111111, 24'hEEEEEE);
    send(24'h222222, 24'hDDDDDD);
    send(24'h333333, 24'hCCCCCC);
    idle(3 * FRAME);

    // Underrun repeat.
    send(24'h800000, 24'h000001);
    idle(3 * FRAME);

    // Accept landing exactly on a frame-start edge.
    wait_phase(FRAME - 1);
    send(24'h5A5A5A, 24'hA5A5A5);
    idle(2 * FRAME);

    // Randomized traffic with random gaps.
    for (int i = 0; i < 10; i++) begin
      send(W'($urandom), W'($urandom));
      idle($urandom_range(0, 2 * FRAME));
    end
    idle(FRAME);

    // Mid-frame reset.
    send(24'h7FFFFF, 24'hFFFFFF);
    wait_phase(116);
    valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    send(24'h0F0F0F, 24'hF0F0F0);
    idle(3 * FRAME);

    checks++;
    if (frames < 20) begin
      errors++;
      $display("FAIL frame_count actual=%0d required=>=20", frames);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
